// File: rtl/game_pkg.sv
// Shared definitions for the turn controller: FSM encoding, mode code,
// player-count limits and the effective player-count clamp.
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] SETUP_MODE  = 3'b010;
    localparam int         MAX_PLAYERS = 4;
    localparam int         MIN_PLAYERS = 2;

    // Clamp the selected player count into the range the board supports.
    // The upper limit is the smaller of the instance width and MAX_PLAYERS,
    // because the turn index is only two bits wide.
    function automatic logic [2:0] eff_players(input logic [2:0] n, input int max_p);
        logic [2:0] hi;
        if (max_p > MAX_PLAYERS)
            hi = 3'(MAX_PLAYERS);
        else if (max_p < MIN_PLAYERS)
            hi = 3'(MIN_PLAYERS);
        else
            hi = 3'(max_p);

        if (n < 3'(MIN_PLAYERS))
            return 3'(MIN_PLAYERS);
        else if (n > hi)
            return hi;
        else
            return n;
    endfunction

endpackage

// File: rtl/turn_ptr.sv
// Modulo-neff turn pointer with a registered one-hot player enable.
module turn_ptr #(
    parameter int MAX_PLAYERS = game_pkg::MAX_PLAYERS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   advance,
    input  logic                   clear,
    input  logic [2:0]             neff,
    output logic [1:0]             turn,
    output logic [MAX_PLAYERS-1:0] p_da
);

    logic [1:0]             turn_n;
    logic [MAX_PLAYERS-1:0] p_da_n;

    // Next turn: clear wins; an advance past the last player wraps to 0.
    // Comparing with >= also recovers if N shrank below the current turn.
    always_comb begin
        turn_n = turn;
        if (clear)
            turn_n = 2'd0;
        else if (advance)
            turn_n = ({1'b0, turn} >= (neff - 3'd1)) ? 2'd0 : turn + 2'd1;
        for (int i = 0; i < MAX_PLAYERS; i++)
            p_da_n[i] = (i == int'(turn_n));
    end

    // Turn index and its one-hot decode update together, so p_da never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn <= 2'd0;
            p_da <= MAX_PLAYERS'(1);
        end else begin
            turn <= turn_n;
            p_da <= p_da_n;
        end
    end

endmodule

// File: rtl/turn_ctrl.sv
// Turn controller: steps the current player's counter by `steps` tiles with
// a fixed idle gap between D pulses, and passes the turn on a miss.
module turn_ctrl #(
    parameter int STEP_GAP    = 1,
    parameter int MAX_PLAYERS = game_pkg::MAX_PLAYERS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             M,
    input  logic [2:0]             N,
    input  logic                   move_req,
    input  logic [2:0]             steps,
    input  logic                   miss,
    output logic                   D,
    output logic [MAX_PLAYERS-1:0] p_da,
    output logic [1:0]             turn,
    output logic                   busy,
    output logic                   done
);

    import game_pkg::*;

    localparam logic [2:0] GAP_LOAD = 3'(STEP_GAP - 1);

    state_t     state;
    logic [2:0] remaining;
    logic [2:0] gap_cnt;
    logic       d_q;
    logic       done_q;
    logic       setup;
    logic       advance;
    logic [2:0] neff;

    assign setup   = (M == SETUP_MODE);
    assign neff    = eff_players(N, MAX_PLAYERS);
    // A miss only passes the turn when idle and not shadowed by a move request.
    assign advance = (state == S_IDLE) && miss && !move_req && !setup;

    // Setup mode kills D and done in the very cycle it appears.
    assign D    = d_q    & ~setup;
    assign done = done_q & ~setup;

    turn_ptr #(
        .MAX_PLAYERS (MAX_PLAYERS)
    ) u_turn_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance),
        .clear   (setup),
        .neff    (neff),
        .turn    (turn),
        .p_da    (p_da)
    );

    // Move sequencer: IDLE -> (STEP -> GAP*)* -> DONE -> IDLE, outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= 3'd0;
            gap_cnt   <= 3'd0;
            d_q       <= 1'b0;
            done_q    <= 1'b0;
            busy      <= 1'b0;
        end else if (setup) begin
            state     <= S_IDLE;
            remaining <= 3'd0;
            gap_cnt   <= 3'd0;
            d_q       <= 1'b0;
            done_q    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (move_req) begin
                        busy <= 1'b1;
                        if (steps != 3'd0) begin
                            remaining <= steps;
                            d_q       <= 1'b1;
                            state     <= S_STEP;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_STEP: begin
                    d_q       <= 1'b0;
                    remaining <= remaining - 3'd1;
                    if (remaining == 3'd1) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 3'd0) begin
                        d_q   <= 1'b1;
                        state <= S_STEP;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_ctrl.sv
// Scoreboard bench for turn_ctrl: stimulus pushes expected output events,
// a monitor pops and compares them as the DUT produces them.
module tb_turn_ctrl;

    localparam int G = 1;

    typedef enum int {EV_TURN = 0, EV_BUP = 1, EV_D = 2, EV_DONE = 3, EV_BDN = 4} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         cyc;
        logic [1:0] tn;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  cur_turn = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] M = 3'd0;
    logic [2:0] N = 3'd4;
    logic       move_req = 1'b0;
    logic [2:0] steps = 3'd0;
    logic       miss = 1'b0;
    logic       D;
    logic [3:0] p_da;
    logic [1:0] turn;
    logic       busy;
    logic       done;

    turn_ctrl #(.STEP_GAP(G), .MAX_PLAYERS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .M        (M),
        .N        (N),
        .move_req (move_req),
        .steps    (steps),
        .miss     (miss),
        .D        (D),
        .p_da     (p_da),
        .turn     (turn),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input ev_kind_t k, input int c, input int t);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.tn   = 2'(t);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t        e;
        logic [3:0] pexp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got event at cycle %0d turn=%0d p_da=%b, required none",
                     k.name(), cyc, turn, p_da);
            return;
        end
        e = exp_q.pop_front();
        pexp = 4'b0001 << e.tn;
        if (e.kind != k || e.cyc != cyc || e.tn != turn || p_da != pexp) begin
            n_bad++;
            $display("FAIL event_%s: got %s@%0d turn=%0d p_da=%b, required %s@%0d turn=%0d p_da=%b",
                     e.kind.name(), k.name(), cyc, turn, p_da, e.kind.name(), e.cyc, e.tn, pexp);
        end
    endtask

    // Monitor: sample just after each rising edge, emit events in fixed order.
    initial begin
        logic       pb;
        logic [1:0] pt;
        pb = 1'b0;
        pt = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            if (turn != pt)    observe(EV_TURN);
            if (busy && !pb)   observe(EV_BUP);
            if (D)             observe(EV_D);
            if (done)          observe(EV_DONE);
            if (!busy && pb)   observe(EV_BDN);
            pt = turn;
            pb = busy;
        end
    end

    task automatic do_move(input int s, input logic with_miss, input logic miss_busy);
        int e;
        int last;
        e = cyc + 1;
        push(EV_BUP, e, cur_turn);
        if (s == 0) begin
            push(EV_DONE, e, cur_turn);
            push(EV_BDN, e + 1, cur_turn);
        end else begin
            for (int i = 0; i < s; i++)
                push(EV_D, e + i * (G + 1), cur_turn);
            last = e + (s - 1) * (G + 1);
            push(EV_DONE, last + 1, cur_turn);
            push(EV_BDN, last + 2, cur_turn);
        end
        steps    = 3'(s);
        move_req = 1'b1;
        miss     = with_miss;
        @(negedge clk);
        move_req = 1'b0;
        miss     = miss_busy;
        @(negedge clk);
        miss     = 1'b0;
        repeat (s * (G + 1) + 3) @(negedge clk);
    endtask

    task automatic do_miss(input int t);
        push(EV_TURN, cyc + 1, t);
        miss = 1'b1;
        @(negedge clk);
        miss = 1'b0;
        cur_turn = t;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_setup(input logic [2:0] n);
        if (cur_turn != 0) push(EV_TURN, cyc + 1, 0);
        M = 3'b010;
        N = n;
        @(negedge clk);
        M = 3'd0;
        cur_turn = 0;
        @(negedge clk);
    endtask

    initial begin
        int e;

        // Reset state, asserted asynchronously before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_D", 32'(D), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_turn", 32'(turn), 32'd0);
        chk("rst_p_da", 32'(p_da), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-tile move from player 0
        do_move(3, 1'b0, 1'b0);

        // Three players, turn cycles through 1, 2, 0
        N = 3'd3;
        do_miss(1);
        do_miss(2);
        do_miss(0);

        // Zero-tile move: done immediately, one busy cycle
        do_move(0, 1'b0, 1'b0);

        // move_req and miss together, then a miss while busy: both misses dropped
        do_move(2, 1'b1, 1'b1);

        // Setup aborts a five-tile move after the second D and clears the turn
        do_miss(1);
        e = cyc + 1;
        push(EV_BUP, e, 1);
        push(EV_D, e, 1);
        push(EV_D, e + 2, 1);
        push(EV_TURN, e + 4, 0);
        push(EV_BDN, e + 4, 0);
        steps    = 3'd5;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        repeat (3) @(negedge clk);
        M = 3'b010;
        @(negedge clk);
        M = 3'd0;
        cur_turn = 0;
        repeat (4) @(negedge clk);

        // N=1 clamps to two players
        do_setup(3'd1);
        do_miss(1);
        do_miss(0);
        do_miss(1);

        // N=7 clamps to four players
        do_setup(3'd7);
        do_miss(1);
        do_miss(2);
        do_miss(3);
        do_miss(0);

        // Reset in the middle of a seven-tile move stops all further pulses
        e = cyc + 1;
        push(EV_BUP, e, 0);
        push(EV_D, e, 0);
        push(EV_BDN, e + 2, 0);
        steps    = 3'd7;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_D", 32'(D), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_p_da", 32'(p_da), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Every expected event must have been seen
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: got %0d still pending, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
